// File: rtl/cnt_pkg.sv
// cnt_pkg: shared types and default widths for the timer controller slice.
//   cnt_ctrl_state_e : controller FSM state (IDLE, RUN)
//   CntW             : default counter/threshold width
//   PscW             : default prescaler width
package cnt_pkg;

  localparam int unsigned CntW = 16;
  localparam int unsigned PscW = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cnt_ctrl_state_e;

endpackage

// File: rtl/cnt_presc.sv
// cnt_presc: PW-bit prescaler producing a one-cycle tick every psc_i+1 cycles while running.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   run_i         : count while high; the count is held at 0 while low
//   clr_i         : synchronous clear of the count (takes priority over counting)
//   psc_i         : terminal value; tick when count == psc_i
//   tick_o        : terminal tick, combinational from the count
module cnt_presc
  import cnt_pkg::*;
#(
  parameter int unsigned PW = PscW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          run_i,
  input  logic          clr_i,
  input  logic [PW-1:0] psc_i,
  output logic          tick_o
);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o = run_i & (cnt_q == psc_i);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || !run_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cnt_ctrl.sv
// cnt_ctrl: timer controller sitting in front of a threshold up-counter.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (shared with the counter)
//   start_i       : start/restart pulse; latches thr_i, psc_i, oneshot_i
//   stop_i        : stop pulse (wins over start_i while running; ignored when idle)
//   oneshot_i     : 1 = stop after the first period, 0 = periodic
//   thr_i, psc_i  : threshold and prescale value, sampled only on start
//   irq_clr_i     : clears irq_o and ovf_o
//   cnt_en_o      : counter enable, every psc+1 cycles while running
//   cnt_clr_o     : counter clear on start/restart/stop
//   cnt_thr_o     : registered threshold for the counter
//   cnt_tc_i      : counter terminal-count flag
//   busy_o        : controller is running
//   irq_o         : sticky period-elapsed flag
//   ovf_o         : sticky flag, a period elapsed while irq_o was already set
module cnt_ctrl
  import cnt_pkg::*;
#(
  parameter int unsigned W  = CntW,
  parameter int unsigned PW = PscW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          oneshot_i,
  input  logic [W-1:0]  thr_i,
  input  logic [PW-1:0] psc_i,
  input  logic          irq_clr_i,
  output logic          cnt_en_o,
  output logic          cnt_clr_o,
  output logic [W-1:0]  cnt_thr_o,
  input  logic          cnt_tc_i,
  output logic          busy_o,
  output logic          irq_o,
  output logic          ovf_o
);

  cnt_ctrl_state_e state_q;
  logic [W-1:0]    thr_q;
  logic [PW-1:0]   psc_q;
  logic            oneshot_q;
  logic            irq_q;
  logic            ovf_q;

  logic run;
  logic do_stop;
  logic do_start;
  logic tick;
  logic ev;

  assign run      = (state_q == RUN);
  assign do_stop  = run & stop_i;
  // stop wins when both arrive while running; in IDLE stop is ignored so start still acts
  assign do_start = start_i & ~do_stop;

  cnt_presc #(
    .PW(PW)
  ) u_presc (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .run_i (run),
    .clr_i (cnt_clr_o),
    .psc_i (psc_q),
    .tick_o(tick)
  );

  assign cnt_clr_o = do_start | do_stop;
  // A start or stop cycle never advances the counter, which also suppresses the period event
  assign cnt_en_o  = tick & ~start_i & ~stop_i;
  assign ev        = cnt_en_o & cnt_tc_i;

  assign cnt_thr_o = thr_q;
  assign busy_o    = run;
  assign irq_o     = irq_q;
  assign ovf_o     = ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      thr_q     <= '0;
      psc_q     <= '0;
      oneshot_q <= 1'b0;
      irq_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (do_stop) begin
        state_q <= IDLE;
      end else if (do_start) begin
        state_q   <= RUN;
        thr_q     <= thr_i;
        psc_q     <= psc_i;
        oneshot_q <= oneshot_i;
      end else if (ev && oneshot_q) begin
        // Counter has already wrapped to 0 on this event, so no clear is issued
        state_q <= IDLE;
      end

      // Set wins on irq; a coincident clear still acknowledges the overflow
      if (ev) begin
        irq_q <= 1'b1;
      end else if (irq_clr_i) begin
        irq_q <= 1'b0;
      end

      if (irq_clr_i) begin
        ovf_q <= 1'b0;
      end else if (ev && irq_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnt_ctrl.sv
module tb_cnt_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, oneshot, irq_clr;
  logic [W-1:0]  thr;
  logic [PW-1:0] psc;
  logic          cnt_en, cnt_clr, cnt_tc, busy, irq, ovf;
  logic [W-1:0]  cnt_thr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cnt_ctrl #(
    .W (W),
    .PW(PW)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .stop_i   (stop),
    .oneshot_i(oneshot),
    .thr_i    (thr),
    .psc_i    (psc),
    .irq_clr_i(irq_clr),
    .cnt_en_o (cnt_en),
    .cnt_clr_o(cnt_clr),
    .cnt_thr_o(cnt_thr),
    .cnt_tc_i (cnt_tc),
    .busy_o   (busy),
    .irq_o    (irq),
    .ovf_o    (ovf)
  );

  // Downstream threshold up-counter: wraps to 0 on the enable where it equals thr.
  logic [W-1:0] cnt_q;
  assign cnt_tc = (cnt_q == cnt_thr);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (cnt_clr) cnt_q <= '0;
    else if (cnt_en)  cnt_q <= cnt_tc ? '0 : cnt_q + 1'b1;
  end

  typedef struct {
    logic         st, sp, osh, ic;
    logic [15:0]  thr;
    logic [7:0]   psc;
    logic         en, clr, busy, irq, ovf;
    logic [15:0]  tho;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic st, logic sp, logic osh, logic ic, logic [15:0] t,
                              logic [7:0] p, logic en, logic clr, logic bsy, logic iq,
                              logic ov, logic [15:0] tho);
    vec_t v;
    v.st = st; v.sp = sp; v.osh = osh; v.ic = ic; v.thr = t; v.psc = p;
    v.en = en; v.clr = clr; v.busy = bsy; v.irq = iq; v.ovf = ov; v.tho = tho;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge; outputs are sampled 3 time units later.
  task automatic step(input logic st, input logic sp, input logic osh, input logic ic,
                      input logic [15:0] t, input logic [7:0] p);
    @(posedge clk);
    #1;
    start = st; stop = sp; oneshot = osh; irq_clr = ic; thr = t; psc = p;
    #3;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
  endtask

  int n_en;

  initial begin
    // Periodic thr=3 psc=1 from T0, irq/ovf, clear, then stop+start and stop-in-IDLE.
    //              st sp os ic thr psc   en clr bsy irq ovf tho
    vecs[0]  = mk(1, 0, 0, 0, 3, 1,      0, 1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 9, 5,      0, 0, 1, 0, 0, 3);
    vecs[2]  = mk(0, 0, 0, 0, 9, 5,      1, 0, 1, 0, 0, 3);
    vecs[3]  = mk(0, 0, 0, 0, 9, 5,      0, 0, 1, 0, 0, 3);
    vecs[4]  = mk(0, 0, 0, 0, 9, 5,      1, 0, 1, 0, 0, 3);
    vecs[5]  = mk(0, 0, 0, 0, 9, 5,      0, 0, 1, 0, 0, 3);
    vecs[6]  = mk(0, 0, 0, 0, 9, 5,      1, 0, 1, 0, 0, 3);
    vecs[7]  = mk(0, 0, 0, 0, 9, 5,      0, 0, 1, 0, 0, 3);
    vecs[8]  = mk(0, 0, 0, 0, 9, 5,      1, 0, 1, 0, 0, 3);
    vecs[9]  = mk(0, 0, 0, 0, 9, 5,      0, 0, 1, 1, 0, 3);
    vecs[10] = mk(0, 0, 0, 0, 9, 5,      1, 0, 1, 1, 0, 3);
    vecs[11] = mk(0, 0, 0, 0, 9, 5,      0, 0, 1, 1, 0, 3);
    vecs[12] = mk(0, 0, 0, 0, 9, 5,      1, 0, 1, 1, 0, 3);
    vecs[13] = mk(0, 0, 0, 0, 9, 5,      0, 0, 1, 1, 0, 3);
    vecs[14] = mk(0, 0, 0, 0, 9, 5,      1, 0, 1, 1, 0, 3);
    vecs[15] = mk(0, 0, 0, 0, 9, 5,      0, 0, 1, 1, 0, 3);
    vecs[16] = mk(0, 0, 0, 0, 9, 5,      1, 0, 1, 1, 0, 3);
    vecs[17] = mk(0, 0, 0, 0, 9, 5,      0, 0, 1, 1, 1, 3);
    vecs[18] = mk(0, 0, 0, 1, 9, 5,      1, 0, 1, 1, 1, 3);
    vecs[19] = mk(0, 0, 0, 0, 9, 5,      0, 0, 1, 0, 0, 3);
    vecs[20] = mk(1, 1, 0, 0, 7, 2,      0, 1, 1, 0, 0, 3);
    vecs[21] = mk(0, 0, 0, 0, 9, 5,      0, 0, 0, 0, 0, 3);
    vecs[22] = mk(0, 1, 0, 0, 9, 5,      0, 0, 0, 0, 0, 3);

    rst_n = 1'b0; start = 0; stop = 0; oneshot = 0; irq_clr = 0; thr = '0; psc = '0;
    #13;
    chk("rst en", cnt_en, 0);
    chk("rst clr", cnt_clr, 0);
    chk("rst busy", busy, 0);
    chk("rst irq", irq, 0);
    chk("rst ovf", ovf, 0);
    chk("rst thr", cnt_thr, 0);
    #9 rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].st, vecs[i].sp, vecs[i].osh, vecs[i].ic, vecs[i].thr, vecs[i].psc);
      chk($sformatf("v%0d en", i), cnt_en, vecs[i].en);
      chk($sformatf("v%0d clr", i), cnt_clr, vecs[i].clr);
      chk($sformatf("v%0d busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d irq", i), irq, vecs[i].irq);
      chk($sformatf("v%0d ovf", i), ovf, vecs[i].ovf);
      chk($sformatf("v%0d thr_o", i), cnt_thr, vecs[i].tho);
    end

    // One-shot thr=3 psc=0: ev at T4, idle from T5, irq held until cleared.
    step(1, 0, 1, 0, 3, 0);
    chk("os start clr", cnt_clr, 1);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk($sformatf("os T%0d en", k), cnt_en, 1);
      chk($sformatf("os T%0d busy", k), busy, 1);
    end
    chk("os T4 tc", cnt_tc, 1);
    idle();
    chk("os T5 busy", busy, 0);
    chk("os T5 irq", irq, 1);
    for (int k = 6; k <= 8; k++) begin
      idle();
      chk($sformatf("os T%0d en", k), cnt_en, 0);
      chk($sformatf("os T%0d irq", k), irq, 1);
    end
    step(0, 0, 0, 1, 0, 0);
    idle();
    chk("os irq cleared", irq, 0);

    // Restart mid-run: thr 3->5 at T5, next ev at T11.
    step(1, 0, 0, 0, 3, 0);
    for (int k = 1; k <= 4; k++) idle();
    step(1, 0, 0, 0, 5, 0);
    chk("rs T5 clr", cnt_clr, 1);
    chk("rs T5 en", cnt_en, 0);
    chk("rs T5 irq", irq, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("rs T6 thr_o", cnt_thr, 5);
    chk("rs T6 en", cnt_en, 1);
    for (int k = 7; k <= 10; k++) begin
      idle();
      chk($sformatf("rs T%0d tc", k), cnt_tc, 0);
    end
    idle();
    chk("rs T11 ev", cnt_en & cnt_tc, 1);
    chk("rs T11 irq", irq, 0);
    idle();
    chk("rs T12 irq", irq, 1);
    step(0, 1, 0, 1, 0, 0);
    idle();

    // thr=0 psc=0: ev every cycle; clear coincident with ev keeps irq, drops ovf.
    step(1, 0, 0, 0, 0, 0);
    idle();
    chk("t0 T1 ev", cnt_en & cnt_tc, 1);
    idle();
    chk("t0 T2 ev", cnt_en & cnt_tc, 1);
    chk("t0 T2 irq", irq, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("t0 T3 ev", cnt_en & cnt_tc, 1);
    chk("t0 T3 ovf", ovf, 1);
    idle();
    chk("t0 T4 irq", irq, 1);
    chk("t0 T4 ovf", ovf, 0);
    chk("t0 T4 ev", cnt_en & cnt_tc, 1);
    step(0, 1, 0, 1, 0, 0);
    idle();

    // psc = 2^PW-1: enable every 256 cycles.
    step(1, 0, 0, 0, 0, 8'd255);
    n_en = 0;
    for (int c = 1; c <= 520; c++) begin
      idle();
      if (cnt_en) n_en++;
      if (c == 255 || c == 257 || c == 511) chk($sformatf("psmax T%0d en", c), cnt_en, 0);
      if (c == 256 || c == 512) chk($sformatf("psmax T%0d en", c), cnt_en, 1);
    end
    chk("psmax enable count", n_en, 2);
    step(0, 1, 0, 1, 0, 0);
    idle();

    // Asynchronous reset mid-run with irq and ovf set.
    step(1, 0, 0, 0, 2, 0);
    for (int k = 1; k <= 7; k++) idle();
    chk("ar pre irq", irq, 1);
    chk("ar pre ovf", ovf, 1);
    chk("ar pre thr", cnt_thr, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar busy", busy, 0);
    chk("ar irq", irq, 0);
    chk("ar ovf", ovf, 0);
    chk("ar thr", cnt_thr, 0);
    chk("ar en", cnt_en, 0);
    #2 rst_n = 1'b1;
    idle();
    chk("ar post busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
